// File: rtl/conv_result_streamer.sv
// Streams memZ results out on a valid/ready interface after a convolution.
// memZ reads go through a 2-entry prefetch FIFO gated by a credit count.
module conv_result_streamer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   sizeX,
   input  logic [ADDR_WIDTH-1:0]   sizeY,
   output logic                    memZ_rd_en,
   output logic [ADDR_WIDTH:0]     memZ_rd_addr,
   input  logic [2*DATA_WIDTH-1:0] memZ_rd_data,
   output logic [2*DATA_WIDTH-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic                    busy_out,
   output logic                    done_out
);
   localparam int AW1 = ADDR_WIDTH + 1;
   localparam int ZW  = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [AW1-1:0]   len_q, len_d;
   logic [AW1-1:0]   rd_addr_q, rd_addr_d;
   logic [AW1-1:0]   beat_q, beat_d;
   logic             inflight_q, inflight_d;
   logic [ZW-1:0]    fifo_q [2];
   logic             wr_ptr_q, rd_ptr_q;
   logic [1:0]       cnt_q;

   logic [AW1-1:0]   len_calc;
   logic [2:0]       pend;
   logic             issue, pop, push, flush, is_last;

   assign len_calc  = {1'b0, sizeX} + {1'b0, sizeY} - AW1'(1);
   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = fifo_q[rd_ptr_q];
   assign pop       = out_valid & out_ready;
   assign push      = inflight_q;
   // Words already committed: buffered plus the read whose data lands this cycle.
   assign pend      = {1'b0, cnt_q} + {2'b00, inflight_q};
   assign is_last   = (beat_q == len_q - AW1'(1));
   assign out_last  = out_valid & is_last;

   assign memZ_rd_en   = issue;
   assign memZ_rd_addr = rd_addr_q;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      rd_addr_d = rd_addr_q;
      beat_d    = beat_q;
      issue     = 1'b0;
      flush     = 1'b0;
      busy_out  = 1'b0;
      done_out  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d     = len_calc;
               rd_addr_d = '0;
               beat_d    = '0;
               flush     = 1'b1;
               state_d   = (sizeX == '0 || sizeY == '0) ? S_DONE : S_STREAM;
            end
         end
         S_STREAM: begin
            busy_out = 1'b1;
            issue    = (rd_addr_q < len_q) && (pend < (3'd2 + {2'b00, pop}));
            if (issue) rd_addr_d = rd_addr_q + AW1'(1);
            if (pop) begin
               beat_d = beat_q + AW1'(1);
               if (is_last) state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_out = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      inflight_d = issue;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         rd_addr_q  <= '0;
         beat_q     <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         rd_addr_q  <= rd_addr_d;
         beat_q     <= beat_d;
         inflight_q <= inflight_d;
      end
   end

   // Reset drops inflight_q, so a read issued just before reset is never pushed.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         cnt_q     <= 2'd0;
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= memZ_rd_data;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: tb/tb_conv_result_streamer.sv
// Bench for conv_result_streamer: random memZ contents and ready patterns,
// expected stream derived from len = sizeX + sizeY - 1 and the memZ image.
module tb_conv_result_streamer;
   localparam int DW = 8;
   localparam int AW = 5;
   localparam int ZW = 2 * DW;

   logic          clk = 1'b0;
   logic          rst, start, out_ready;
   logic [AW-1:0] sizeX, sizeY;
   logic          memZ_rd_en;
   logic [AW:0]   memZ_rd_addr;
   logic [ZW-1:0] memZ_rd_data, out_data;
   logic          out_valid, out_last, busy_out, done_out;

   logic [ZW-1:0] mem [64];
   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   conv_result_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .sizeX(sizeX), .sizeY(sizeY),
      .memZ_rd_en(memZ_rd_en), .memZ_rd_addr(memZ_rd_addr), .memZ_rd_data(memZ_rd_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy_out(busy_out), .done_out(done_out)
   );

   // memZ model: one-cycle read latency, junk on the bus when not reading
   always @(posedge clk)
      memZ_rd_data <= memZ_rd_en ? mem[memZ_rd_addr] : ZW'($urandom);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_rd_en"}, 32'(memZ_rd_en), 32'd0);
      chk({tag, "_addr"},  32'(memZ_rd_addr), 32'd0);
      chk({tag, "_data"},  32'(out_data), 32'd0);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_last"},  32'(out_last), 32'd0);
      chk({tag, "_busy"},  32'(busy_out), 32'd0);
      chk({tag, "_done"},  32'(done_out), 32'd0);
   endtask

   // mode 0: ready always high, 1: ready low 5 cycles once beat 2 is at the head,
   // 2: random ready. restart pulses start mid-stream; rst_beat >= 0 resets at that beat.
   task automatic run(input int sx, input int sy, input int mode, input bit restart, input int rst_beat);
      int L, beats, issued, done_cyc, hold;
      bit prev_stall, pop, finished;
      logic [ZW-1:0] prev_data;
      L = (sx == 0 || sy == 0) ? 0 : sx + sy - 1;
      @(negedge clk);
      rst = 1'b0; sizeX = AW'(sx); sizeY = AW'(sy); start = 1'b1; out_ready = 1'b1;
      beats = 0; issued = 0; hold = 0; prev_stall = 1'b0; prev_data = '0; finished = 1'b0;
      done_cyc = (L == 0) ? 1 : -1;
      for (int k = 1; k < 400 && !finished; k++) begin
         @(negedge clk);
         start = restart && (k == 4);
         sizeX = AW'($urandom); sizeY = AW'($urandom);
         case (mode)
            0: out_ready = 1'b1;
            1: if (beats >= 2 && hold < 5) begin out_ready = 1'b0; hold++; end
               else out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (rst_beat >= 0 && beats == rst_beat && out_valid) begin
            rst = 1'b1;
            #1;
            chk("pre_rst_data", 32'(out_data), 32'(mem[beats]));
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk_idle_outputs("post_rst");
            return;
         end
         #1;
         chk("busy", 32'(busy_out), 32'(L > 0 && beats < L));
         chk("done", 32'(done_out), 32'(k == done_cyc));
         if (k < 3) chk("early_valid", 32'(out_valid), 32'd0);
         if (k == 1 && L > 0) chk("first_rd", {25'd0, memZ_rd_en, memZ_rd_addr}, {25'd0, 1'b1, 6'd0});
         if (memZ_rd_en) begin
            chk("rd_addr", 32'(memZ_rd_addr), 32'(issued));
            chk("rd_bound", 32'(issued < L), 32'd1);
            issued++;
            chk("credit", 32'(issued - beats - (out_valid && out_ready) <= 2), 32'd1);
         end
         chk("valid_bound", 32'(out_valid && beats >= L), 32'd0);
         if (out_valid) chk("last", 32'(out_last), 32'(beats == L - 1));
         else           chk("last_idle", 32'(out_last), 32'd0);
         if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(prev_data));
         end
         pop = out_valid && out_ready;
         if (pop) begin
            chk("data", 32'(out_data), 32'(mem[beats]));
            if (mode == 0) chk("beat_time", 32'(k), 32'(beats + 3));
            beats++;
            if (beats == L) done_cyc = k + 1;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         if (done_cyc > 0 && k == done_cyc + 1) finished = 1'b1;
      end
      chk("finished", 32'(finished), 32'd1);
      chk("beat_count", 32'(beats), 32'(L));
      chk("read_count", 32'(issued), 32'(L));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b0; sizeX = '0; sizeY = '0;
      for (int i = 0; i < 64; i++) mem[i] = ZW'(16'h0100 + i);
      repeat (3) @(negedge clk);
      #1;
      chk_idle_outputs("reset");
      rst = 1'b0;

      run(4, 3, 0, 1'b0, -1);
      run(4, 3, 1, 1'b0, -1);
      run(0, 7, 0, 1'b0, -1);
      run(7, 0, 2, 1'b0, -1);
      for (int i = 0; i < 64; i++) mem[i] = ZW'($urandom);
      run(31, 31, 2, 1'b0, -1);
      run(31, 31, 0, 1'b0, -1);
      run(5, 6, 2, 1'b1, -1);
      run(4, 3, 0, 1'b0, 2);
      run(4, 3, 0, 1'b0, -1);
      run(1, 1, 2, 1'b0, -1);
      for (int r = 0; r < 6; r++)
         run($urandom_range(0, 31), $urandom_range(0, 31), 2, r[0], -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/conv_result_streamer.md
# conv_result_streamer

Downstream stage of the convolution core: once a convolution finishes, this block reads the result memory (memZ) sequentially and streams every result word out on a valid/ready interface. It runs the memZ read port through a 2-entry prefetch buffer, so it sustains one beat per cycle under continuous ready and never loses or duplicates data under backpressure. It is typically triggered by the core's done pulse and reports its own busy/done status.

## Interface
- DATA_WIDTH, 8, width of X/Y samples; result words are 2*DATA_WIDTH bits.
- ADDR_WIDTH, 5, X/Y address width; memZ address is ADDR_WIDTH+1 bits.

- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a readout; sampled only in IDLE.
- sizeX  in  ADDR_WIDTH  length of X; sampled at start.
- sizeY  in  ADDR_WIDTH  length of Y; sampled at start.
- memZ_rd_en  out  1  memZ read strobe.
- memZ_rd_addr  out  ADDR_WIDTH+1  memZ read address.
- memZ_rd_data  in  2*DATA_WIDTH  memZ read data, valid exactly 1 cycle after memZ_rd_en.
- out_data  out  2*DATA_WIDTH  stream data (buffer head).
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready; a beat transfers when out_valid and out_ready are both high.
- out_last  out  1  high with the final beat.
- busy_out  out  1  readout in progress.
- done_out  out  1  one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE: on start, latch len = sizeX + sizeY - 1 (ADDR_WIDTH+1 bits, computed without overflow); clear the read address, beat counter and buffer.
    - If sizeX == 0 or sizeY == 0, go to DONE (zero beats).
    - Otherwise go to STREAM.
  - STREAM: go to DONE on the handshake of beat len-1.
  - DONE: pulse done_out for one cycle, then return to IDLE.
- Read issue in STREAM: assert memZ_rd_en when both hold:
  - rd_addr < len;
  - (buffer occupancy + in-flight reads − pop this cycle) < 2, where pop = out_valid & out_ready.
- rd_addr increments by 1 on each issue.
- Read data is written into the 2-entry FIFO on the cycle after its issue. The credit rule guarantees the FIFO never overflows.
- out_valid = FIFO not empty; out_data = FIFO head.
- out_last = out_valid & (beat counter == len-1). The beat counter increments on each handshake.
- busy_out is high in STREAM only.
- start in STREAM or DONE is ignored, with no effect on sizes or counters.
- Largest case: sizeX = sizeY = 2^ADDR_WIDTH-1 gives len = 2^(ADDR_WIDTH+1)-3, which fits in the address width; addresses never wrap.

## Timing
- Reset values: memZ_rd_en=0, memZ_rd_addr=0, out_data=0, out_valid=0, out_last=0, busy_out=0, done_out=0; FSM in IDLE; FIFO empty; no read in flight.
- start sampled at edge N:
  - cycle N+1: STREAM, busy_out=1, memZ_rd_en=1, addr=0;
  - cycle N+2: addr 0 data captured into the FIFO;
  - cycle N+3: out_valid=1 with word 0.
- With out_ready held high: one beat per cycle, addresses issued back to back. For len L, the last beat is at cycle N+2+L; done_out=1 at N+3+L with busy_out=0.
- Zero-length start: done_out=1 at cycle N+1; busy_out, out_valid and memZ_rd_en stay 0.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_last hold stable. At most 2 words are buffered or in flight; issue stops until a pop.
- out_ready high while out_valid=0 has no effect.
- rst mid-operation takes effect at the next edge:
  - all outputs return to reset values and the FIFO is flushed;
  - data returning from a read issued before reset is discarded.

## Test plan
- sizeX=4, sizeY=3, memZ[i]=0x0100+i, ready=1, start at N -> beats 0x0100..0x0105 at cycles N+3..N+8, out_last only on 0x0105, done_out at N+9, busy_out high N+1..N+8.
- Same sizes, out_ready low for 5 cycles after the second beat -> out_data frozen at 0x0102; memZ_rd_en stays low once 2 words are pending; sequence complete with no loss or duplicates.
- sizeX=0, sizeY=7 -> done_out at N+1; no memZ_rd_en; no out_valid.
- sizeX=sizeY=31 (ADDR_WIDTH=5), random out_ready -> 61 beats at addresses 0..60 in order; out_last on address 60; no read beyond 60.
- start pulsed again during STREAM with different sizes -> ignored; original len completes unchanged.
- rst asserted during beat 3 of a 6-beat run -> next cycle all outputs are 0; a new start then produces the full 6-beat sequence from address 0.
